// File: rtl/ro_freq_counter.sv
// Gated rising-edge counter for the selected ring oscillator.
// Latches the count with a sticky overflow flag and can read it out MSB-first on one pin.
module ro_freq_counter #(
  parameter int CNT_W       = 24,
  parameter int GATE_W      = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              ro_in,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              shift_req,
  output logic [CNT_W-1:0]  count_o,
  output logic              overflow_o,
  output logic              done_o,
  output logic              busy_o,
  output logic              sdo,
  output logic              sdo_valid
);

  localparam int BIT_W = $clog2(CNT_W + 2);

  typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ro_dly;
  logic                   rise;
  logic [GATE_W-1:0]      gate_cnt;
  logic [CNT_W-1:0]       edge_cnt;
  logic                   ovf_int;
  logic                   shifting;
  logic [CNT_W:0]         shreg;
  logic [BIT_W-1:0]       bit_cnt;

  // ro_in is asynchronous to wb_clk_i, so it passes through a synchronizer before edge detection
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync_q <= '0;
      ro_dly <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ro_in};
      ro_dly <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~ro_dly;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      ovf_int    <= 1'b0;
      count_o    <= '0;
      overflow_o <= 1'b0;
      done_o     <= 1'b0;
      busy_o     <= 1'b0;
      shifting   <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      sdo        <= 1'b0;
      sdo_valid  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // An active shift blocks start; start wins over a simultaneous shift request
          if (shifting) begin
            if (bit_cnt != '0) begin
              sdo       <= shreg[CNT_W];
              sdo_valid <= 1'b1;
              shreg     <= {shreg[CNT_W-1:0], 1'b0};
              bit_cnt   <= bit_cnt - 1'b1;
              busy_o    <= 1'b1;
            end else begin
              sdo       <= 1'b0;
              sdo_valid <= 1'b0;
              shifting  <= 1'b0;
              busy_o    <= 1'b0;
            end
          end else if (start) begin
            gate_cnt <= (gate_len == '0) ? GATE_W'(1) : gate_len;
            done_o   <= 1'b0;
            state    <= ARM;
            busy_o   <= 1'b1;
          end else if (done_o && shift_req) begin
            shreg    <= {overflow_o, count_o};
            bit_cnt  <= BIT_W'(CNT_W + 1);
            shifting <= 1'b1;
            busy_o   <= 1'b1;
          end else begin
            busy_o <= 1'b0;
          end
        end
        ARM: begin
          edge_cnt <= '0;
          ovf_int  <= 1'b0;
          state    <= COUNT;
          busy_o   <= 1'b1;
        end
        COUNT: begin
          if (rise) begin
            if (edge_cnt == '1) ovf_int <= 1'b1;
            else                edge_cnt <= edge_cnt + 1'b1;
          end
          gate_cnt <= gate_cnt - 1'b1;
          if (gate_cnt == GATE_W'(1)) state <= DONE;
          busy_o <= 1'b1;
        end
        DONE: begin
          count_o    <= edge_cnt;
          overflow_o <= ovf_int;
          done_o     <= 1'b1;
          state      <= IDLE;
          busy_o     <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Bench for ro_freq_counter: directed and randomized oscillator patterns against a sample-stream model.
// A second instance with a 4-bit counter covers saturation and overflow.
module tb_ro_freq_counter;
  localparam int CNT_W   = 24;
  localparam int GATE_W  = 20;
  localparam int S       = 2;
  localparam int SMALL_W = 4;
  localparam int MAXV    = (1 << CNT_W) - 1;
  localparam int SMAXV   = (1 << SMALL_W) - 1;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i = 1'b1;
  logic              ro_in = 1'b0;
  logic              start = 1'b0;
  logic              shift_req = 1'b0;
  logic [GATE_W-1:0] gate_len = '0;

  logic [CNT_W-1:0]   count_o;
  logic               overflow_o, done_o, busy_o, sdo, sdo_valid;
  logic [SMALL_W-1:0] small_count;
  logic               small_ovf, small_done, small_busy, small_sdo, small_sdo_valid;

  ro_freq_counter #(.CNT_W(CNT_W), .GATE_W(GATE_W), .SYNC_STAGES(S)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .ro_in(ro_in), .start(start),
    .gate_len(gate_len), .shift_req(shift_req), .count_o(count_o),
    .overflow_o(overflow_o), .done_o(done_o), .busy_o(busy_o), .sdo(sdo), .sdo_valid(sdo_valid)
  );

  ro_freq_counter #(.CNT_W(SMALL_W), .GATE_W(GATE_W), .SYNC_STAGES(S)) dut_small (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .ro_in(ro_in), .start(start),
    .gate_len(gate_len), .shift_req(shift_req), .count_o(small_count),
    .overflow_o(small_ovf), .done_o(small_done), .busy_o(small_busy), .sdo(small_sdo),
    .sdo_valid(small_sdo_valid)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int errors = 0;
  int checks = 0;
  bit samp [0:65535];
  int cyc = 0;
  int ro_mode = 0;
  int ro_period = 4;
  int ro_phase = 0;
  int exp_cnt, exp_ovf, exp_scnt, exp_sovf;

  // Value of ro_in seen at each rising edge; reset holds the synchronizer at zero
  always @(posedge wb_clk_i) begin
    samp[cyc] = wb_rst_i ? 1'b0 : ro_in;
    cyc++;
  end

  always @(negedge wb_clk_i) begin
    case (ro_mode)
      0:       ro_in = 1'b0;
      1:       begin ro_in = (ro_phase % ro_period) < (ro_period / 2); ro_phase++; end
      default: ro_in = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic tick();
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // A rise counted at edge t is a 0->1 step between samples t-S-1 and t-S
  function automatic int model_rises(int e0, int g);
    int n = 0;
    for (int j = e0 + 2 - S; j <= e0 + g + 1 - S; j++)
      if (samp[j] && !samp[j-1]) n++;
    return n;
  endfunction

  task automatic applyStimulus(input int g, input bit dbl, input bit with_shift);
    int e0, eff, n, busy_cnt;
    logic early, sv_seen;
    eff = (g == 0) ? 1 : g;
    e0 = cyc;
    gate_len = GATE_W'(g);
    start = 1'b1;
    shift_req = with_shift;
    tick();
    start = 1'b0;
    shift_req = 1'b0;
    busy_cnt = int'(busy_o);
    early = done_o;
    sv_seen = sdo_valid;
    for (int i = 1; i <= eff + 1; i++) begin
      start = dbl && (i == 1);
      tick();
      start = 1'b0;
      busy_cnt += int'(busy_o);
      early |= done_o;
      sv_seen |= sdo_valid;
    end
    tick();
    n = model_rises(e0, eff);
    exp_cnt  = (n > MAXV) ? MAXV : n;
    exp_ovf  = (n > MAXV) ? 1 : 0;
    exp_scnt = (n > SMAXV) ? SMAXV : n;
    exp_sovf = (n > SMAXV) ? 1 : 0;
    checkOutput("done_early", 32'(early), 0);
    checkOutput("done_on_time", 32'(done_o), 1);
    checkOutput("busy_cycles", busy_cnt, eff + 2);
    checkOutput("busy_after", 32'(busy_o), 0);
    checkOutput("no_shift", 32'(sv_seen), 0);
    checkOutput("count", 32'(count_o), exp_cnt);
    checkOutput("overflow", 32'(overflow_o), exp_ovf);
    checkOutput("small_count", 32'(small_count), exp_scnt);
    checkOutput("small_overflow", 32'(small_ovf), exp_sovf);
    if (dbl) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        checkOutput("single_done_busy", 32'(busy_o), 0);
        checkOutput("single_done_hold", 32'(done_o), 1);
      end
    end
  endtask

  task automatic do_shift();
    logic [CNT_W:0] word;
    word = {1'(exp_ovf), CNT_W'(exp_cnt)};
    shift_req = 1'b1;
    tick();
    shift_req = 1'b0;
    checkOutput("sdo_valid_load", 32'(sdo_valid), 0);
    checkOutput("busy_load", 32'(busy_o), 1);
    for (int i = 0; i <= CNT_W; i++) begin
      start = (i == 8);
      shift_req = (i == 3);
      tick();
      start = 1'b0;
      shift_req = 1'b0;
      checkOutput("sdo_valid", 32'(sdo_valid), 1);
      checkOutput("sdo_bit", 32'(sdo), 32'(word[CNT_W-i]));
      checkOutput("busy_shift", 32'(busy_o), 1);
    end
    tick();
    checkOutput("sdo_valid_end", 32'(sdo_valid), 0);
    checkOutput("sdo_end", 32'(sdo), 0);
    checkOutput("busy_end", 32'(busy_o), 0);
    checkOutput("done_kept", 32'(done_o), 1);
    checkOutput("count_kept", 32'(count_o), exp_cnt);
    checkOutput("overflow_kept", 32'(overflow_o), exp_ovf);
    tick();
    checkOutput("start_ignored", 32'(busy_o), 0);
  endtask

  initial begin
    tick();
    tick();
    checkOutput("rst_count", 32'(count_o), 0);
    checkOutput("rst_overflow", 32'(overflow_o), 0);
    checkOutput("rst_done", 32'(done_o), 0);
    checkOutput("rst_busy", 32'(busy_o), 0);
    checkOutput("rst_sdo", 32'(sdo), 0);
    checkOutput("rst_sdo_valid", 32'(sdo_valid), 0);
    wb_rst_i = 1'b0;
    tick();
    tick();

    $display("[TB] idle input, 50-cycle window");
    ro_mode = 0;
    applyStimulus(50, 1'b0, 1'b0);
    checkOutput("count_idle", 32'(count_o), 0);

    $display("[TB] period-4 square wave, 100-cycle window");
    ro_mode = 1;
    ro_period = 4;
    tick();
    tick();
    applyStimulus(100, 1'b0, 1'b0);
    checkOutput("count_p4", 32'(count_o), 25);
    checkOutput("small_sat", 32'(small_count), 15);
    checkOutput("small_sat_ovf", 32'(small_ovf), 1);
    applyStimulus(20, 1'b0, 1'b0);
    checkOutput("small_p4_20", 32'(small_count), 5);
    checkOutput("small_p4_20_ovf", 32'(small_ovf), 0);

    $display("[TB] start and shift_req together");
    applyStimulus(12, 1'b0, 1'b1);

    $display("[TB] random pattern then serial readout");
    ro_mode = 2;
    applyStimulus(int'($urandom_range(60, 250)), 1'b0, 1'b0);
    do_shift();

    $display("[TB] reset in the middle of a window");
    ro_mode = 1;
    gate_len = GATE_W'(100);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 31; i++) tick();
    wb_rst_i = 1'b1;
    #1;
    checkOutput("mid_rst_count", 32'(count_o), 0);
    checkOutput("mid_rst_overflow", 32'(overflow_o), 0);
    checkOutput("mid_rst_done", 32'(done_o), 0);
    checkOutput("mid_rst_busy", 32'(busy_o), 0);
    checkOutput("mid_rst_small_ovf", 32'(small_ovf), 0);
    tick();
    tick();
    wb_rst_i = 1'b0;
    tick();
    tick();
    applyStimulus(8, 1'b0, 1'b0);
    checkOutput("count_after_rst", 32'(count_o), 2);

    $display("[TB] zero-length window with a second start while busy");
    applyStimulus(0, 1'b1, 1'b0);

    $display("[TB] randomized windows");
    for (int k = 0; k < 5; k++) begin
      ro_mode = int'($urandom_range(1, 2));
      ro_period = int'($urandom_range(2, 9));
      applyStimulus(int'($urandom_range(1, 300)), 1'b0, 1'b0);
    end
    do_shift();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ro_freq_counter.md
Name: ro_freq_counter

Overview:
Gated edge counter that measures the ring-oscillator signal chosen by the 16:1 oscillator select mux. It counts rising edges of that signal over a programmable window of wb_clk_i cycles and latches the result with a sticky overflow flag. The result is read either in parallel or as a serial bitstream, MSB first, so it can be brought out on a single io pin. It sits directly downstream of the mux output, inside user_project_wrapper.

Parameters:
CNT_W, 24, edge counter / result width
GATE_W, 20, gate window length width
SYNC_STAGES, 2, synchronizer flops on ro_in (minimum 2)

Ports:
wb_clk_i  input  1  measurement clock; all state on rising edge
wb_rst_i  input  1  asynchronous active-high reset
ro_in  input  1  asynchronous oscillator signal from the select mux
start  input  1  request to begin a measurement; sampled only in IDLE
gate_len  input  GATE_W  window length in wb_clk_i cycles; latched at start
shift_req  input  1  request serial readout of the last result
count_o  output  CNT_W  last measured edge count
overflow_o  output  1  last measurement saturated
done_o  output  1  result valid; held until next start or reset
busy_o  output  1  high in ARM, COUNT, DONE and during serial shift
sdo  output  1  serial result bit
sdo_valid  output  1  qualifies sdo

Behaviour:
- Reset (async, wb_rst_i=1): state=IDLE; all synchronizer flops, edge_cnt, gate_cnt, count_o, overflow_o, done_o, busy_o, sdo, sdo_valid, shift register and bit counter = 0. A reset during a measurement or during a shift discards it entirely. No partial result is kept.
- Input path: ro_in -> SYNC_STAGES flops -> one delay flop. rise = sync_out & ~delayed. Measurement is exact only for f_ro < f_clk/2. Faster inputs alias and are outside scope.
- FSM states: IDLE, ARM, COUNT, DONE.
- IDLE, start=1 and not shifting: gate_cnt <= max(gate_len,1), so gate_len=0 is treated as 1. done_o <= 0. Next state ARM.
- ARM (1 cycle): edge_cnt <= 0, overflow <= 0. Next state COUNT. Edges during ARM are not counted.
- COUNT: each cycle, if rise, edge_cnt increments, saturating at 2^CNT_W-1. An increment attempted at saturation sets internal overflow (sticky). gate_cnt decrements each cycle. The cycle in which gate_cnt==1 is the last counted cycle (its rise is included); next state DONE. The window is exactly gate_len cycles.
- DONE (1 cycle): count_o <= edge_cnt; overflow_o <= overflow; done_o <= 1. Next state IDLE.
- Timing: with start sampled at edge E0, done_o and count_o update at edge E0+gate_len+2.
- busy_o is registered and equals (state != IDLE) | shifting.
- start is ignored when the state is not IDLE or a shift is active. No queueing.
- Serial readout: in IDLE with done_o=1 and shift_req=1, load shreg <= {overflow_o, count_o} (CNT_W+1 bits) and set shifting.
  - Then one bit per cycle, MSB (overflow) first. sdo_valid=1 for exactly CNT_W+1 consecutive cycles, starting the cycle after the load.
  - After the last bit: sdo_valid <= 0, sdo <= 0, shifting ends.
  - shift_req while shifting, or while done_o=0, is ignored.
  - count_o, overflow_o and done_o are unchanged by shifting.
- If start and shift_req are both asserted in IDLE in the same cycle, start has priority: a measurement begins and the shift request is dropped.

Test Plan:
- Reset, then ro_in held 0, gate_len=50, start pulse -> done_o=1 exactly 52 cycles after the start edge; count_o=0; overflow_o=0; busy_o high for 52 cycles.
- ro_in square wave of period 4 clk (free-running before start), gate_len=100 -> count_o=25, overflow_o=0.
- CNT_W=4, ro_in period 4 clk, gate_len=100 -> count_o=15, overflow_o=1. A following run with gate_len=20 -> count_o=5, overflow_o=0.
- Reset in the middle of COUNT (cycle 30 of 100) -> all outputs 0 immediately. A new start with gate_len=8 and ro period 4 -> count_o=2.
- After a measurement with count_o=0x00A5C3 and overflow 0, pulse shift_req -> sdo_valid high for 25 cycles; sdo sequence is 0 then 0x00A5C3 MSB first. start pulsed mid-shift is ignored (busy_o=1, no state change).
- gate_len=0 -> behaves as gate_len=1: done_o 3 cycles after start. Second start pulse while busy -> ignored, only one done rise.
